// File: rtl/tank_pkg.sv
// tank_pkg: shared FSM state type and level-decoding helpers for the tank controller
package tank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        FAULT   = 2'd3
    } tank_state_t;

    // A zero-extended thermometer code 0..01..1 has no bit set in common with itself plus one
    function automatic logic is_thermo(input logic [31:0] v);
        return ((v + 32'd1) & v) == 32'd0;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/tank_level_ctrl_debounce.sv
// level_debounce: samples raw sensors and only passes a value on after it has been stable long enough
module level_debounce #(
    parameter int NSENS    = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NSENS-1:0] lvl,
    output logic [NSENS-1:0] lvl_db
);

    localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE - 1);

    logic [NSENS-1:0] lvl_q, lvl_d, db_q, db_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic             same;

    // Stability counter restarts on any change and saturates once the value is trusted
    always_comb begin
        same   = lvl == lvl_q;
        lvl_d  = lvl;
        stab_d = !same ? '0 : (stab_q == STAB_MAX ? stab_q : stab_q + SW'(1));
        db_d   = (same && stab_q == STAB_MAX) ? lvl_q : db_q;
    end

    // Sample, count and debounced-value registers
    always_ff @(posedge clk_2) begin
        if (reset) begin
            lvl_q  <= '0;
            stab_q <= '0;
            db_q   <= '0;
        end else begin
            lvl_q  <= lvl_d;
            stab_q <= stab_d;
            db_q   <= db_d;
        end
    end

    assign lvl_db = db_q;

endmodule

// File: rtl/tank_level_ctrl.sv
// tank_level_ctrl: debounced level sensing, hysteretic pump FSM, fill watchdog and latched fault
module tank_level_ctrl
    import tank_pkg::*;
#(
    parameter int NSENS        = 4,
    parameter int DEBOUNCE     = 3,
    parameter int FILL_TIMEOUT = 8,
    parameter int LOW_MARK     = 1,
    parameter int LW           = $clog2(NSENS + 1)
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic [NSENS-1:0] lvl,
    input  logic          ack,
    output logic          pump_on,
    output logic          empty,
    output logic          full,
    output logic          fault,
    output logic [LW-1:0] level,
    output logic [1:0]    state_o
);

    localparam int TW = $clog2(FILL_TIMEOUT + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(NSENS);
    localparam logic [LW-1:0] LOW_LVL  = LW'(LOW_MARK);
    localparam logic [TW-1:0] TO_MAX   = TW'(FILL_TIMEOUT - 1);

    logic [NSENS-1:0] lvl_db;
    logic             valid;
    tank_state_t      state_q, state_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [LW-1:0]    prev_q;

    level_debounce #(.NSENS(NSENS), .DEBOUNCE(DEBOUNCE)) u_db (
        .clk_2  (clk_2),
        .reset  (reset),
        .lvl    (lvl),
        .lvl_db (lvl_db)
    );

    assign valid = is_thermo(32'(lvl_db));
    assign level = LW'(popcount(32'(lvl_db)));

    // Next state: inconsistent sensors trump everything, a full tank beats a timeout
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        if (state_q != FAULT && !valid) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level == FULL_LVL) state_d = FULL;
                    else if (level <= LOW_LVL) begin
                        state_d  = FILLING;
                        to_cnt_d = '0;
                    end
                end
                FILLING: begin
                    if (level == FULL_LVL) state_d = FULL;
                    else if (level > prev_q) to_cnt_d = '0;
                    else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                        if (to_cnt_q == TO_MAX) state_d = FAULT;
                    end
                end
                FULL: begin
                    if (level <= LOW_LVL) begin
                        state_d  = FILLING;
                        to_cnt_d = '0;
                    end else if (level < FULL_LVL) state_d = IDLE;
                end
                FAULT: state_d = (ack && valid) ? IDLE : FAULT;
            endcase
        end
    end

    // State, watchdog and previous-level registers
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            prev_q   <= level;
        end
    end

    assign pump_on = state_q == FILLING;
    assign fault   = state_q == FAULT;
    assign empty   = level == '0;
    assign full    = level == FULL_LVL;
    assign state_o = state_q;

endmodule

// File: tb/tb_tank_level_ctrl.sv
// tb_tank_level_ctrl: randomized and directed checks against an edge-level behavioural model
module tb_tank_level_ctrl;

    localparam int NS = 4, DB = 3, FT = 8, LM = 1;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       ack   = 1'b0;
    logic [3:0] lvl   = 4'd0;
    logic       pump_on, empty, full, fault;
    logic [2:0] level;
    logic [1:0] state_o;
    logic [8:0] dut_vec;

    int checks = 0, errors = 0;

    int         m_state, m_prev, m_last, n, run_len;
    logic [3:0] m_db, run_val;

    tank_level_ctrl #(.NSENS(NS), .DEBOUNCE(DB), .FILL_TIMEOUT(FT), .LOW_MARK(LM)) dut (
        .clk_2   (clk_2),
        .reset   (reset),
        .lvl     (lvl),
        .ack     (ack),
        .pump_on (pump_on),
        .empty   (empty),
        .full    (full),
        .fault   (fault),
        .level   (level),
        .state_o (state_o)
    );

    always #5 clk_2 = ~clk_2;

    assign dut_vec = {state_o, level, pump_on, fault, empty, full};

    localparam logic [8:0] RESET_VEC = 9'b00_000_0_0_1_0;

    function automatic logic [8:0] exp_vec();
        int lv;
        lv = $countones(m_db);
        return {2'(m_state), 3'(lv), m_state == 1, m_state == 3, lv == 0, lv == NS};
    endfunction

    // One clock edge: advance the model from the values present at the edge, then settle
    task automatic tick();
        int   lv;
        logic valid;
        @(posedge clk_2);
        n++;
        if (reset) begin
            m_state = 0; m_prev = 0; m_last = n; m_db = '0; run_val = '0; run_len = 1;
        end else begin
            lv    = $countones(m_db);
            valid = m_db == 4'((1 << lv) - 1);
            if (m_state != 3 && !valid) m_state = 3;
            else if (m_state == 0) begin
                if (lv == NS) m_state = 2;
                else if (lv <= LM) begin m_state = 1; m_last = n; end
            end else if (m_state == 1) begin
                if (lv == NS) m_state = 2;
                else if (lv > m_prev) m_last = n;
                else if (n - m_last == FT) m_state = 3;
            end else if (m_state == 2) begin
                if (lv <= LM) begin m_state = 1; m_last = n; end
                else if (lv < NS) m_state = 0;
            end else if (ack && valid) m_state = 0;
            m_prev = lv;
            if (lvl == run_val) run_len++;
            else begin run_val = lvl; run_len = 1; end
            if (run_len >= DB + 1) m_db = run_val;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; lvl = 4'b0000; ack = 1'b0;
        tick(); tick();
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL reset_vals got %b want %b", dut_vec, RESET_VEC);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_model got %b want %b", dut_vec, exp_vec());
        end
        reset = 1'b0;
        tick();
        checks++;
        if (state_o !== 2'd1 || pump_on !== 1'b1) begin
            errors++; $display("FAIL reset_first_fill got state %0d pump %b want 1 1", state_o, pump_on);
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 4; k++) begin
            lvl = 4'((1 << k) - 1);
            repeat (6) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL fill_model cyc %0d got %b want %b", n, dut_vec, exp_vec());
                end
            end
            checks++;
            if (level !== 3'(k)) begin
                errors++; $display("FAIL fill_level got %0d want %0d", level, k);
            end
        end
        checks++;
        if (full !== 1'b1 || state_o !== 2'd2 || pump_on !== 1'b0) begin
            errors++; $display("FAIL fill_full got full %b state %0d pump %b want 1 2 0", full, state_o, pump_on);
        end
        lvl = 4'b0111;
        repeat (6) tick();
        checks++;
        if (state_o !== 2'd0 || pump_on !== 1'b0) begin
            errors++; $display("FAIL full_to_idle got state %0d pump %b want 0 0", state_o, pump_on);
        end
        lvl = 4'b0001;
        repeat (6) tick();
        checks++;
        if (state_o !== 2'd1 || pump_on !== 1'b1) begin
            errors++; $display("FAIL idle_to_fill got state %0d pump %b want 1 1", state_o, pump_on);
        end
    endtask

    task automatic test_glitch();
        lvl = 4'b0011;
        repeat (6) tick();
        for (int p = 1; p <= 2; p++) begin
            lvl = 4'b0111;
            repeat (p) begin
                tick();
                checks++;
                if (level !== 3'd2 || dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL glitch_%0d got %b want level 2 vec %b", p, dut_vec, exp_vec());
                end
            end
            lvl = 4'b0011;
            repeat (5) begin
                tick();
                checks++;
                if (level !== 3'd2 || dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL glitch_%0d_after got %b want level 2 vec %b", p, dut_vec, exp_vec());
                end
            end
        end
        lvl = 4'b0111;
        repeat (6) tick();
        checks++;
        if (level !== 3'd3) begin
            errors++; $display("FAIL glitch_hold got level %0d want 3", level);
        end
    endtask

    task automatic test_timeout();
        bit entered;
        ack = 1'b1; lvl = 4'b1111;
        repeat (6) tick();
        ack = 1'b0;
        repeat (2) tick();
        lvl = 4'b0111;
        repeat (6) tick();
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL timeout_setup got state %0d want 0", state_o);
        end
        lvl = 4'b0001;
        entered = 1'b0;
        for (int i = 0; i < 20 && !entered; i++) begin
            tick();
            entered = state_o == 2'd1;
        end
        checks++;
        if (!entered) begin
            errors++; $display("FAIL timeout_entry got state %0d want 1 within 20 edges", state_o);
        end
        for (int i = 1; i <= FT; i++) begin
            tick();
            checks++;
            if (fault !== (i == FT) || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL timeout_edge_%0d got fault %b vec %b want %b", i, fault, dut_vec, exp_vec());
            end
        end
        checks++;
        if (state_o !== 2'd3) begin
            errors++; $display("FAIL timeout_state got %0d want 3", state_o);
        end
        ack = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL timeout_ack got state %0d want 0", state_o);
        end
        tick();
        checks++;
        if (state_o !== 2'd1 || pump_on !== 1'b1) begin
            errors++; $display("FAIL timeout_refill got state %0d pump %b want 1 1", state_o, pump_on);
        end
        ack = 1'b0;
    endtask

    task automatic test_invalid();
        lvl = 4'b0101;
        repeat (6) tick();
        checks++;
        if (state_o !== 2'd3 || fault !== 1'b1) begin
            errors++; $display("FAIL invalid_fault got state %0d fault %b want 3 1", state_o, fault);
        end
        ack = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (state_o !== 2'd3) begin
                errors++; $display("FAIL invalid_ack_ignored got state %0d want 3", state_o);
            end
        end
        ack = 1'b0; lvl = 4'b0111;
        repeat (6) tick();
        checks++;
        if (state_o !== 2'd3 || level !== 3'd3) begin
            errors++; $display("FAIL invalid_wait got state %0d level %0d want 3 3", state_o, level);
        end
        ack = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd0 || fault !== 1'b0) begin
            errors++; $display("FAIL invalid_clear got state %0d fault %b want 0 0", state_o, fault);
        end
        ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        lvl = 4'b0101;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (dut_vec !== RESET_VEC || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_mid got %b want %b", dut_vec, RESET_VEC);
        end
        reset = 1'b0; lvl = 4'b0000;
        tick();
        checks++;
        if (state_o !== 2'd1 || fault !== 1'b0) begin
            errors++; $display("FAIL reset_mid_resume got state %0d fault %b want 1 0", state_o, fault);
        end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 300; it++) begin
            lvl   = ($urandom_range(0, 9) < 7) ? 4'((1 << $urandom_range(0, 4)) - 1) : 4'($urandom);
            ack   = $urandom_range(0, 3) == 0;
            reset = $urandom_range(0, 60) == 0;
            len   = $urandom_range(1, 7);
            repeat (len) begin
                tick();
                reset = 1'b0;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL random cyc %0d lvl %b got %b want %b", n, lvl, dut_vec, exp_vec());
                end
            end
        end
        ack = 1'b0;
    endtask

    initial begin
        n = 0; m_state = 0; m_prev = 0; m_last = 0; m_db = '0; run_val = '0; run_len = 1;
        test_reset();
        test_fill();
        test_glitch();
        test_timeout();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
